// File: rtl/hash_pkg.sv
// hash_pkg: shared state encoding, rotate helpers and the round-function
// helper used by hash_engine and by future multi-lane engines.
// Helpers work on a MAX_W-bit word and take the live width as an argument,
// so any engine up to MAX_W bits wide can reuse them unchanged.
package hash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hash_state_t;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    // All-ones mask covering the low w bits of a word.
    function automatic word_t width_mask(input int w);
        word_t m;
        if (w >= MAX_W) begin
            m = '1;
        end else begin
            m = (word_t'(1) << w) - word_t'(1);
        end
        return m;
    endfunction

    // Rotate the low w bits of x left by r (1 <= r <= w-1).
    function automatic word_t rotl(input word_t x, input int w, input int r);
        word_t xm;
        xm = x & width_mask(w);
        return ((xm << r) | (xm >> (w - r))) & width_mask(w);
    endfunction

    // Rotate the low w bits of x right by r (1 <= r <= w-1).
    function automatic word_t rotr(input word_t x, input int w, input int r);
        word_t xm;
        xm = x & width_mask(w);
        return ((xm >> r) | (xm << (w - r))) & width_mask(w);
    endfunction

    // Next data operand: (P ^ rotr(K)) + (D ^ ~rotl(K)), modulo 2^w.
    // Bits above w may hold garbage before the final mask; the mask makes
    // the addition wrap exactly like a w-bit adder.
    function automatic word_t round_data(input word_t k, input word_t d,
                                         input word_t p, input int w,
                                         input int r);
        return ((p ^ rotr(k, w, r)) + (d ^ ~rotl(k, w, r))) & width_mask(w);
    endfunction

    // Next prev operand: the old data operand rotated left.
    function automatic word_t round_prev(input word_t d, input int w,
                                         input int r);
        return rotl(d, w, r);
    endfunction

endpackage

// File: rtl/hash_round.sv
// hash_round: one purely combinational mixing round, (K, D, P) -> (D', P').
// WIDTH may be at most hash_pkg::MAX_W; ROT must lie in 1..WIDTH-1.
module hash_round
    import hash_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROT   = 8
) (
    input  logic [WIDTH-1:0] i_key,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_d,
    output logic [WIDTH-1:0] o_p
);

    assign o_d = WIDTH'(round_data(word_t'(i_key), word_t'(i_d), word_t'(i_p),
                                   WIDTH, ROT));
    assign o_p = WIDTH'(round_prev(word_t'(i_d), WIDTH, ROT));

endmodule

// File: rtl/hash_engine.sv
// hash_engine: handshaked, parametrised hash core. Accepts one request in
// IDLE, runs ROUNDS mixing rounds (one per cycle), then holds the digest
// D+P until the consumer takes it. Chaining reuses the last consumed digest
// as the prev operand.
module hash_engine
    import hash_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 2,
    parameter int ROT    = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_prev,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hash,
    output logic [CNT_W-1:0] done_count
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    hash_state_t      r_state;
    logic [RW-1:0]    r_round;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_chain;
    logic [CNT_W-1:0] r_doneCount;

    logic [WIDTH-1:0] w_dNext;
    logic [WIDTH-1:0] w_pNext;
    logic [WIDTH-1:0] w_digest;

    hash_round #(
        .WIDTH (WIDTH),
        .ROT   (ROT)
    ) u_round (
        .i_key (r_k),
        .i_d   (r_d),
        .i_p   (r_p),
        .o_d   (w_dNext),
        .o_p   (w_pNext)
    );

    assign w_digest   = r_d + r_p;
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_hash   = (r_state == DONE) ? w_digest : '0;
    assign done_count = r_doneCount;

    // FSM, operand registers, chain register and completed-digest counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_k         <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_chain     <= '0;
            r_doneCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_k     <= key;
                        r_d     <= in_data;
                        r_p     <= in_chain ? r_chain : in_prev;
                        r_round <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_d     <= w_dNext;
                    r_p     <= w_pNext;
                    r_round <= r_round + RW'(1);
                    if (r_round == LAST_ROUND) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_chain     <= w_digest;
                        r_doneCount <= r_doneCount + CNT_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
